// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS instruction fetch stage.
package mips_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_3000;
  localparam int          WORD_BYTES   = 4;
  localparam int          INSTR_W      = 32;

  // One buffered fetch: the address it came from and the word returned.
  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO holding fetched instructions between imem and decode.
// Flush empties the queue in one cycle. Storage is reset to zero so the head
// reads as zero straight out of reset.
module fetch_buffer
  import mips_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int CW = PW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // A pop on a full buffer does not make room for a push in the same cycle;
  // the producer only pushes when it saw the buffer not full.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy tracking; flush wins over push and pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; written only on an accepted push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/mips_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues one word request at a
// time to instruction memory, and queues returned words for decode.
// A redirect flushes the queue and restarts fetch at the new target.
module mips_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_VECTOR,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  logic [31:0]  fetch_pc;
  logic         started;
  logic         accept;
  logic         pop;
  logic         buf_full;
  logic         buf_empty;
  fetch_entry_t push_entry;
  fetch_entry_t head;

  // Request depends only on registered state so out_ready has no
  // combinational path to imem_req. started keeps imem_req low while in reset.
  assign imem_req  = started && !buf_full;
  assign imem_addr = fetch_pc;

  assign accept = imem_req && imem_ready && !redirect_valid;
  assign pop    = out_valid && out_ready && !redirect_valid;

  assign push_entry.pc    = fetch_pc;
  assign push_entry.instr = imem_rdata;

  assign out_valid = !buf_empty;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

  // Holds off the first request until the first clock after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) started <= 1'b0;
    else      started <= 1'b1;
  end

  // Fetch PC: redirect beats accept; the low two target bits are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                fetch_pc <= RESET_PC;
    else if (redirect_valid) fetch_pc <= redirect_pc & ~32'h0000_0003;
    else if (accept)         fetch_pc <= fetch_pc + 32'(WORD_BYTES);
  end

  fetch_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (accept),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (buf_full),
    .empty     (buf_empty)
  );

endmodule

// File: tb/tb_mips_fetch.sv
// Directed bench for mips_fetch. Inputs are driven and outputs sampled on the
// falling clock edge. The memory model returns addr ^ 0xA5A5A5A5.
module tb_mips_fetch;

  localparam logic [31:0] XK = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ XK;

  mips_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Check a valid head entry: pc and the matching memory word.
  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_pc"}, out_pc, pc);
    chk({tag, "_instr"}, out_instr, pc ^ XK);
  endtask

  // Assert reset for one falling edge, check reset outputs, release on a
  // falling edge so the next rising edge is the first one out of reset.
  task automatic do_reset(input bit ordy, input bit irdy);
    rst = 1'b0;
    redirect_valid = 1'b0;
    out_ready = ordy;
    imem_ready = irdy;
    cyc(1);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0000_3000);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    rst = 1'b1;
  endtask

  initial begin
    cyc(1);

    // Streaming with zero-wait memory.
    do_reset(1'b1, 1'b1);
    cyc(1);
    chk("s_req", 32'(imem_req), 32'd1);
    chk("s_addr", imem_addr, 32'h0000_3000);
    chk("s_valid0", 32'(out_valid), 32'd0);
    cyc(1); chk_head("s0", 32'h0000_3000);
    cyc(1); chk_head("s1", 32'h0000_3004);
    cyc(1); chk_head("s2", 32'h0000_3008);

    // Decode stalled: two pushes then request stops; drain in order.
    do_reset(1'b0, 1'b1);
    cyc(1); chk("b_addr0", imem_addr, 32'h0000_3000);
    cyc(1); chk("b_addr1", imem_addr, 32'h0000_3004);
    cyc(4);
    chk("b_req_full", 32'(imem_req), 32'd0);
    chk("b_addr_full", imem_addr, 32'h0000_3008);
    chk_head("b_h0", 32'h0000_3000);
    out_ready = 1'b1;
    cyc(1);
    chk_head("b_h1", 32'h0000_3004);
    chk("b_req_resume", 32'(imem_req), 32'd1);
    chk("b_addr_resume", imem_addr, 32'h0000_3008);
    cyc(1); chk_head("b_h2", 32'h0000_3008);
    cyc(1); chk_head("b_h3", 32'h0000_300C);

    // Memory wait states: address held, no entry until the response.
    do_reset(1'b1, 1'b0);
    cyc(1); chk("w_addr0", imem_addr, 32'h0000_3000);
    cyc(1); chk("w_addr1", imem_addr, 32'h0000_3000);
    chk("w_valid1", 32'(out_valid), 32'd0);
    cyc(1); chk("w_addr2", imem_addr, 32'h0000_3000);
    cyc(1);
    chk("w_addr3", imem_addr, 32'h0000_3000);
    chk("w_valid3", 32'(out_valid), 32'd0);
    chk("w_req3", 32'(imem_req), 32'd1);
    imem_ready = 1'b1;
    cyc(1);
    chk_head("w_h0", 32'h0000_3000);
    chk("w_addr_next", imem_addr, 32'h0000_3004);
    imem_ready = 1'b0;
    cyc(1);
    chk("w_gap", 32'(out_valid), 32'd0);
    chk("w_addr_hold", imem_addr, 32'h0000_3004);

    // Redirect with a full buffer, then with a response in flight,
    // then back-to-back.
    do_reset(1'b0, 1'b1);
    cyc(3);
    chk("r_full_req", 32'(imem_req), 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_4002; out_ready = 1'b1;
    cyc(1);
    redirect_valid = 1'b0; out_ready = 1'b0;
    chk("r_valid", 32'(out_valid), 32'd0);
    chk("r_req", 32'(imem_req), 32'd1);
    chk("r_addr", imem_addr, 32'h0000_4000);
    cyc(1);
    chk_head("r_h0", 32'h0000_4000);
    chk("r_addr1", imem_addr, 32'h0000_4004);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_5000;
    cyc(1);
    chk("r_drop_valid", 32'(out_valid), 32'd0);
    chk("r_drop_addr", imem_addr, 32'h0000_5000);
    redirect_pc = 32'h0000_6000;
    cyc(1);
    redirect_valid = 1'b0; out_ready = 1'b1;
    chk("r_b2b_valid", 32'(out_valid), 32'd0);
    chk("r_b2b_addr", imem_addr, 32'h0000_6000);
    cyc(1); chk_head("r_b2b_h", 32'h0000_6000);

    // Address wrap at the top of memory.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    cyc(1);
    redirect_valid = 1'b0;
    chk("x_addr", imem_addr, 32'hFFFF_FFFC);
    cyc(1);
    chk_head("x_h0", 32'hFFFF_FFFC);
    chk("x_wrap_addr", imem_addr, 32'h0000_0000);
    cyc(1); chk_head("x_h1", 32'h0000_0000);

    // Asynchronous reset in mid-cycle with two entries buffered.
    do_reset(1'b0, 1'b1);
    cyc(3);
    chk("a_pre_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("a_valid", 32'(out_valid), 32'd0);
    chk("a_req", 32'(imem_req), 32'd0);
    chk("a_addr", imem_addr, 32'h0000_3000);
    cyc(1);
    rst = 1'b1; out_ready = 1'b1;
    cyc(1);
    chk("a_req_rel", 32'(imem_req), 32'd1);
    chk("a_addr_rel", imem_addr, 32'h0000_3000);
    cyc(1); chk_head("a_h0", 32'h0000_3000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
